// File: rtl/bram_sp.sv
// Single-port block RAM with hardware clear sweep; optional parity storage under BRAM_PARITY_EN.
// Latency: 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE, output register gated by bram_regce).
// Backpressure: busy is high during the DEPTH-cycle clear sweep; port accesses are ignored meanwhile.
package bram_pkg;
    localparam int LOW_LATENCY      = 0;
    localparam int HIGH_PERFORMANCE = 1;
    localparam int NC = 0;
    localparam int RF = 1;
    localparam int WF = 2;
endpackage

module bram_sp
    import bram_pkg::*;
#(
    parameter int DW         = 18,
    parameter int DEPTH      = 1024,
    parameter int OREG       = HIGH_PERFORMANCE,
    parameter int WRITE_MODE = WF,
    localparam int BRAMAW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bram_en,
    input  logic              bram_we,
    input  logic [BRAMAW-1:0] bram_addr,
    input  logic [DW-1:0]     bram_dout,
    output logic [DW-1:0]     bram_din,
    input  logic              bram_regce,
    input  logic              clr_req,
    output logic              busy
`ifdef BRAM_PARITY_EN
    ,
    input  logic              par_inj,
    output logic              par_err
`endif
);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state_q, state_d;
    logic [BRAMAW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     lat_q;
    logic [DW-1:0]     rd_word;
    logic              in_range;
    logic              acc;
    logic              wr;

    assign busy     = (state_q == S_CLEAR);
    assign in_range = ({1'b0, bram_addr} < (BRAMAW+1)'(DEPTH));
    assign acc      = !busy && bram_en;
    assign wr       = acc && bram_we && in_range;
    assign rd_word  = in_range ? mem[bram_addr] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + BRAMAW'(1);
                if (cnt_q == BRAMAW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array has no reset: contents survive reset until the sweep overwrites them.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr) begin
            mem[bram_addr] <= bram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_q <= '0;
        end else if (acc) begin
            if (!bram_we) begin
                lat_q <= rd_word;
            end else if (WRITE_MODE == WF) begin
                lat_q <= bram_dout;
            end else if (WRITE_MODE == RF) begin
                lat_q <= rd_word;
            end
        end
    end

`ifdef BRAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_lat_q;
    logic rd_mis;

    // Mismatch between the stored even-parity bit and the recomputed one.
    assign rd_mis = in_range ? ((^mem[bram_addr]) ^ par_mem[bram_addr]) : 1'b0;

    always_ff @(posedge clk) begin
        if (busy) begin
            par_mem[cnt_q] <= 1'b0;
        end else if (wr) begin
            par_mem[bram_addr] <= (^bram_dout) ^ par_inj;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_lat_q <= 1'b0;
        end else if (acc) begin
            if (!bram_we) begin
                par_lat_q <= rd_mis;
            end else if (WRITE_MODE == WF) begin
                par_lat_q <= par_inj;
            end else if (WRITE_MODE == RF) begin
                par_lat_q <= rd_mis;
            end
        end
    end
`endif

    generate
        if (OREG == HIGH_PERFORMANCE) begin : g_oreg
            logic [DW-1:0] oreg_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    oreg_q <= '0;
                end else if (bram_regce) begin
                    oreg_q <= lat_q;
                end
            end
            assign bram_din = oreg_q;
`ifdef BRAM_PARITY_EN
            logic par_oreg_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    par_oreg_q <= 1'b0;
                end else if (bram_regce) begin
                    par_oreg_q <= par_lat_q;
                end
            end
            assign par_err = par_oreg_q;
`endif
        end else begin : g_noreg
            logic unused_regce;
            assign unused_regce = bram_regce;
            assign bram_din     = lat_q;
`ifdef BRAM_PARITY_EN
            assign par_err = par_lat_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_bram_sp.sv
// Directed bench: three bram_sp builds (LL/WF/1024, HP/RF/1024, HP/NC/1000) share one stimulus stream.
module tb_bram_sp;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, we, regce, clr_req;
    logic [9:0]  addr;
    logic [17:0] dout;
    logic [17:0] din_ll, din_hp, din_nc;
    logic        busy_ll, busy_hp, busy_nc;
`ifdef BRAM_PARITY_EN
    logic        par_inj;
    logic        perr_ll, perr_hp, perr_nc;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_sp #(.DW(18), .DEPTH(1024), .OREG(LOW_LATENCY), .WRITE_MODE(WF)) u_ll (
        .clk(clk), .rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
        .bram_dout(dout), .bram_din(din_ll), .bram_regce(regce),
        .clr_req(clr_req), .busy(busy_ll)
`ifdef BRAM_PARITY_EN
        , .par_inj(par_inj), .par_err(perr_ll)
`endif
    );

    bram_sp #(.DW(18), .DEPTH(1024), .OREG(HIGH_PERFORMANCE), .WRITE_MODE(RF)) u_hp (
        .clk(clk), .rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
        .bram_dout(dout), .bram_din(din_hp), .bram_regce(regce),
        .clr_req(clr_req), .busy(busy_hp)
`ifdef BRAM_PARITY_EN
        , .par_inj(par_inj), .par_err(perr_hp)
`endif
    );

    bram_sp #(.DW(18), .DEPTH(1000), .OREG(HIGH_PERFORMANCE), .WRITE_MODE(NC)) u_nc (
        .clk(clk), .rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
        .bram_dout(dout), .bram_din(din_nc), .bram_regce(regce),
        .clr_req(clr_req), .busy(busy_nc)
`ifdef BRAM_PARITY_EN
        , .par_inj(par_inj), .par_err(perr_nc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic e, input logic w, input logic [9:0] a, input logic [17:0] d);
        en   = e;
        we   = w;
        addr = a;
        dout = d;
        tick();
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 10'd0, 18'd0);
    endtask

    initial begin
        int n;
        int n_nc;
        rst = 1'b0; en = 1'b0; we = 1'b0; addr = '0; dout = '0;
        regce = 1'b1; clr_req = 1'b0;
`ifdef BRAM_PARITY_EN
        par_inj = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy_ll", 32'(busy_ll), 32'd1);
        chk("rst_busy_nc", 32'(busy_nc), 32'd1);
        chk("rst_din_ll", 32'(din_ll), 32'd0);
        chk("rst_din_hp", 32'(din_hp), 32'd0);

        // Power-up sweep length for both depths
        rst  = 1'b1;
        n    = 0;
        n_nc = 0;
        while (busy_ll && n < 3000) begin
            tick();
            n++;
            if (!busy_nc && n_nc == 0) n_nc = n;
        end
        chk("sweep_len_1024", 32'(n), 32'd1024);
        chk("sweep_len_1000", 32'(n_nc), 32'd1000);

        access(1'b1, 1'b1, 10'h3FE, 18'h12345);
        chk("ll_wf_wr", 32'(din_ll), 32'h12345);
        access(1'b1, 1'b0, 10'h3FF, 18'h0);
        chk("ll_rd_cleared", 32'(din_ll), 32'h0);
        access(1'b1, 1'b0, 10'h3FE, 18'h0);
        chk("ll_rd_3fe", 32'(din_ll), 32'h12345);
        chk("hp_not_early", 32'(din_hp), 32'h0);
        idle();
        chk("hp_rd_2cyc", 32'(din_hp), 32'h12345);

        // LOW_LATENCY write-first
        access(1'b1, 1'b1, 10'd5, 18'h2A5A5);
        chk("ll_wf_5", 32'(din_ll), 32'h2A5A5);
        access(1'b1, 1'b0, 10'd5, 18'h0);
        chk("ll_rd_5", 32'(din_ll), 32'h2A5A5);

        // HIGH_PERFORMANCE read-first
        access(1'b1, 1'b1, 10'd7, 18'h00011);
        access(1'b1, 1'b1, 10'd7, 18'h3FFFF);
        access(1'b1, 1'b0, 10'd7, 18'h0);
        chk("hp_rf_old", 32'(din_hp), 32'h00011);
        idle();
        chk("hp_rd_new", 32'(din_hp), 32'h3FFFF);

        // No-change mode
        access(1'b1, 1'b1, 10'd1, 18'h1);
        access(1'b1, 1'b0, 10'd1, 18'h0);
        access(1'b1, 1'b1, 10'd2, 18'h55);
        chk("ll_wf_2", 32'(din_ll), 32'h55);
        chk("nc_out_1", 32'(din_nc), 32'h1);
        idle();
        chk("nc_hold", 32'(din_nc), 32'h1);

        // Output register frozen while regce=0
        access(1'b1, 1'b1, 10'd3, 18'h3);
        regce = 1'b0;
        access(1'b1, 1'b0, 10'd3, 18'h0);
        chk("frz0", 32'(din_nc), 32'h1);
        idle();
        chk("frz1", 32'(din_nc), 32'h1);
        idle();
        chk("frz2", 32'(din_nc), 32'h1);
        regce = 1'b1;
        idle();
        chk("regce_resume", 32'(din_nc), 32'h3);

        // Out-of-range on the 1000-deep build
        access(1'b1, 1'b1, 10'd1010, 18'h5);
        access(1'b1, 1'b0, 10'd3, 18'h0);
        access(1'b1, 1'b0, 10'd1010, 18'h0);
        chk("nc_pre_oor", 32'(din_nc), 32'h3);
        idle();
        chk("nc_oor_zero", 32'(din_nc), 32'h0);

        // Requested clear, with a re-request and dropped writes mid-sweep
        for (int i = 0; i < 10; i++) access(1'b1, 1'b1, 10'(i), 18'h0FFFF);
        idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_start", 32'(busy_ll), 32'd1);
        n = 0;
        while (busy_ll && n < 3000) begin
            n++;
            clr_req = (n == 300);
            if (n >= 1010 && n < 1020) begin
                en = 1'b1; we = 1'b1; addr = 10'(n - 1010); dout = 18'h777;
            end else begin
                en = 1'b0; we = 1'b0; addr = '0; dout = '0;
            end
            tick();
        end
        clr_req = 1'b0;
        en = 1'b0; we = 1'b0;
        chk("clr_busy_len", 32'(n), 32'd1024);
        chk("clr_hold", 32'(din_ll), 32'h0FFFF);
        for (int i = 0; i < 10; i++) begin
            access(1'b1, 1'b0, 10'(i), 18'h0);
            chk($sformatf("clr_zero_%0d", i), 32'(din_ll), 32'h0);
        end
        idle();

        // Reset during a sweep restarts a full sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (500) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_ll), 32'd1);
        chk("rst_mid_din", 32'(din_ll), 32'h0);
        tick();
        rst = 1'b1;
        n = 0;
        while (busy_ll && n < 3000) begin
            tick();
            n++;
        end
        chk("rst_restart_len", 32'(n), 32'd1024);

`ifdef BRAM_PARITY_EN
        par_inj = 1'b1;
        access(1'b1, 1'b1, 10'd9, 18'h3);
        par_inj = 1'b0;
        access(1'b1, 1'b0, 10'd9, 18'h0);
        chk("par_inj_err", 32'(perr_ll), 32'd1);
        chk("par_inj_dat", 32'(din_ll), 32'h3);
        access(1'b1, 1'b1, 10'd8, 18'h3);
        chk("par_hp_align", 32'(perr_hp), 32'd1);
        access(1'b1, 1'b0, 10'd8, 18'h0);
        chk("par_ok", 32'(perr_ll), 32'd0);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
